bits_to_vec_packer: RTL
=======================

Name: bits_to_vec_packer

Overview:
- Reassembles a stream of single bits into WIDTH-bit vectors. It is the inverse of the vector-splitting blocks, which break a vector into individual bits.
- Input is a valid/ready bit stream. Output is a registered vector with a valid/ready handshake.
- Sits between bit-serial producers (stimulus/serial links) and vector consumers in the bench/DUT fabric.
- Has one assembly register plus one output slot, so a new word can be collected while the previous word waits.

Parameters:
- WIDTH, 3, bits per assembled vector; legal range 2..32.
- MSB_FIRST, 1, 1: first accepted bit lands in vec_out[WIDTH-1]; 0: first bit lands in vec_out[0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort of the partial word being assembled
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  packer can accept bit_in this cycle
- vec_out  output  WIDTH  assembled vector, registered
- vec_valid  output  1  vec_out holds an unconsumed word
- vec_ready  input  1  consumer accepts vec_out this cycle
- bit_count  output  $clog2(WIDTH)+1  number of bits currently held in the assembly register

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On reset:
  - asm_q=0, bit_count=0, vec_out=0, vec_valid=0.
  - bit_ready=1 as soon as reset deasserts.
- Reset mid-word or mid-handshake discards everything. No partial word is ever output.
- Accept: bit_valid && bit_ready at a rising edge.
- Shift:
  - MSB_FIRST=1: asm_q <= {asm_q[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: asm_q <= {bit_in, asm_q[WIDTH-1:1]}.
  - bit_count increments on each accept.
- Completion: an accept while bit_count==WIDTH-1.
  - The word, including the incoming bit, is loaded into vec_out.
  - vec_valid is set at that same edge, so latency is 0 cycles after the last bit's edge.
  - bit_count returns to 0 and asm_q is cleared.
- Output drain: vec_valid && vec_ready at an edge clears vec_valid. vec_out keeps its last value.
- Simultaneous drain and completion in the same cycle: the new word replaces the old one and vec_valid stays 1. No bubble occurs.
- Backpressure: bit_ready = !(bit_count==WIDTH-1 && vec_valid && !vec_ready).
  - bit_ready is combinational on vec_ready.
  - Bits 0..WIDTH-2 of the next word are always accepted while the slot is full.
- Sustained throughput is one word per WIDTH cycles with continuous bit_valid and vec_ready=1.
- bit_valid=0 cycles: all state is held.
- vec_out and vec_valid are stable while vec_valid && !vec_ready.
- clear:
  - asm_q<=0 and bit_count<=0.
  - A bit presented in the same cycle is dropped, even if accepted. clear has priority over completion.
  - clear does not touch vec_out or vec_valid.
- States: COLLECT (bit_count < WIDTH-1 or output slot free), STALL (bit_count==WIDTH-1 and slot full and !vec_ready). STALL→COLLECT on vec_ready or clear.
- All outputs are free of X after reset. bit_in=X on a non-accepted cycle must not corrupt state.

Optional Feature:
- Macro PACKER_PARITY_EN.
- Defined:
  - Adds output vec_par (1 bit), the even-parity XOR of vec_out.
  - vec_par is registered in the same edge as vec_out and is 0 on reset.
  - vec_par follows the same stability rules as vec_out.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, WIDTH=3, MSB_FIRST=1, bits 1,0,1 on consecutive cycles with vec_ready=1 -> vec_out=3'b101 and vec_valid=1 after the 3rd edge; vec_valid=0 one cycle later; bit_count sequence 1,2,0.
- MSB_FIRST=0, bits 1,1,0 -> vec_out=3'b011.
- Continuous stream 0..7 (each value sent as 3 bits MSB-first), vec_ready=1 -> vec_out sequence 0,1,...,7; one word every 3 cycles, no bubbles.
- vec_ready=0, stream 3'b110 then 3'b001 -> first word held stable. After 2 bits of the second word, bit_ready=0 while bit_count=2. Raising vec_ready: 3rd bit accepted in the same cycle, vec_out=3'b001, vec_valid stays 1.
- After 2 bits (1,1), assert clear with bit_valid=1 -> bit_count=0 and that bit is dropped. Next bits 0,0,1 -> vec_out=3'b001. A pending vec_out is unaffected by clear.
- Assert reset asynchronously mid-word with vec_valid=1 -> vec_valid=0, vec_out=0, bit_count=0 immediately. With PACKER_PARITY_EN, 3'b111 -> vec_par=1 and 3'b101 -> vec_par=0.

Source files
------------

// File: rtl/bits_to_vec_packer_if.sv
// rtl/bits_to_vec_packer_if.sv - bit stream in / vector stream out bundle for the packer (vec_par present with PACKER_PARITY_EN)
interface bits_to_vec_packer_if #(
   parameter int WIDTH = 3
);
   logic                     clear;
   logic                     bit_in;
   logic                     bit_valid;
   logic                     bit_ready;
   logic [WIDTH-1:0]         vec_out;
   logic                     vec_valid;
   logic                     vec_ready;
   logic [$clog2(WIDTH):0]   bit_count;
`ifdef PACKER_PARITY_EN
   logic                     vec_par;
`endif

   // Producer/consumer side: drives bits in and accepts vectors out
   modport master (
      output clear, bit_in, bit_valid, vec_ready,
`ifdef PACKER_PARITY_EN
      input  vec_par,
`endif
      input  bit_ready, vec_out, vec_valid, bit_count
   );

   // Packer side
   modport slave (
      input  clear, bit_in, bit_valid, vec_ready,
`ifdef PACKER_PARITY_EN
      output vec_par,
`endif
      output bit_ready, vec_out, vec_valid, bit_count
   );
endinterface

// File: rtl/bits_to_vec_packer.sv
// rtl/bits_to_vec_packer.sv - serial bit to WIDTH-bit vector packer, optional parity output under PACKER_PARITY_EN
module bits_to_vec_packer #(
   parameter int WIDTH     = 3,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   bits_to_vec_packer_if.slave   bus
);
   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   // STALL: the last bit of a word is due but the output slot is still full
   typedef enum logic {COLLECT, STALL} state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  asm_q;
   logic [WIDTH-1:0]  shifted;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic [WIDTH-1:0]  vec_q;
   logic              valid_q;
   logic              valid_d;
   logic              bit_ready;
   logic              accept;
   logic              drain;
   logic              complete;
`ifdef PACKER_PARITY_EN
   logic              par_q;
`endif

   // Handshake decode and next-state values; completion is suppressed by clear
   always_comb begin
      shifted   = MSB_FIRST ? {asm_q[WIDTH-2:0], bus.bit_in} : {bus.bit_in, asm_q[WIDTH-1:1]};
      bit_ready = !(state_q == STALL && !bus.vec_ready);
      accept    = bus.bit_valid && bit_ready;
      drain     = valid_q && bus.vec_ready;
      complete  = accept && !bus.clear && (count_q == LAST);
      count_d   = count_q;
      if (bus.clear || complete)
         count_d = '0;
      else if (accept)
         count_d = count_q + CW'(1);
      valid_d   = valid_q;
      if (complete)
         valid_d = 1'b1;
      else if (drain)
         valid_d = 1'b0;
   end

   // Assembly register, output slot and stall state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= COLLECT;
         asm_q   <= '0;
         count_q <= '0;
         vec_q   <= '0;
         valid_q <= 1'b0;
`ifdef PACKER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         if (bus.clear || complete)
            asm_q <= '0;
         else if (accept)
            asm_q <= shifted;
         if (complete) begin
            vec_q <= shifted;
`ifdef PACKER_PARITY_EN
            par_q <= ^shifted;
`endif
         end
         count_q <= count_d;
         valid_q <= valid_d;
         state_q <= (count_d == LAST && valid_d) ? STALL : COLLECT;
      end
   end

   assign bus.bit_ready = bit_ready;
   assign bus.vec_out   = vec_q;
   assign bus.vec_valid = valid_q;
   assign bus.bit_count = count_q;
`ifdef PACKER_PARITY_EN
   assign bus.vec_par   = par_q;
`endif
endmodule
